hex_digit_scanner: RTL and testbench

HEX_DIGIT_SCANNER -- requirements
Module: hex_digit_scanner

---
 rtl/hex_digit_scanner_pkg.sv | 38 +++
 rtl/hex_digit_scanner_tick_gen.sv | 29 ++
 rtl/hex_digit_scanner.sv | 74 +++++++
 tb/tb_hex_digit_scanner.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hex_digit_scanner_pkg.sv
// Shared constants and small helpers for the four-digit multiplexed hex display scanner.
package hex_digit_scanner_pkg;

    localparam int NUM_DIGITS      = 4;
    localparam int DIGIT_W         = 4;
    localparam int DEFAULT_CLK_DIV = 50000;
    localparam int WORD_W          = NUM_DIGITS * DIGIT_W;
    localparam int IDX_W           = $clog2(NUM_DIGITS);

    function automatic logic [DIGIT_W-1:0] digit_of(input logic [WORD_W-1:0] word,
                                                    input logic [IDX_W-1:0]  idx);
        logic [DIGIT_W-1:0] d;
        d = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) d = word[k*DIGIT_W +: DIGIT_W];
        end
        return d;
    endfunction

    function automatic logic [NUM_DIGITS-1:0] one_hot(input logic [IDX_W-1:0] idx);
        logic [NUM_DIGITS-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    // True when digit idx and every more-significant digit are zero.
    function automatic logic upper_zero(input logic [WORD_W-1:0] word,
                                        input logic [IDX_W-1:0]  idx);
        logic z;
        z = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k >= int'(idx) && word[k*DIGIT_W +: DIGIT_W] != '0) z = 1'b0;
        end
        return z;
    endfunction

endpackage

// File: rtl/hex_digit_scanner_tick_gen.sv
// Free-running prescaler: tick is high for one clock at the terminal count CLK_DIV-1.
module tick_gen
    import hex_digit_scanner_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int              CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hex_digit_scanner.sv
// Four-digit hex display scanner with a one-deep pending buffer that only swaps into the
// displayed word at a frame boundary, plus optional leading-zero blanking.
module hex_digit_scanner
    import hex_digit_scanner_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic        blank_lz,
    output logic [3:0]  nibble,
    output logic [3:0]  digit_en,
    output logic        digit_blank,
    output logic        frame_start
);

    logic              tick;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [WORD_W-1:0] pending;
    logic              pending_full;
    logic [WORD_W-1:0] display;
    logic [WORD_W-1:0] display_next;
    logic              accept;
    logic              transfer;

    tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    assign load_ready   = ~pending_full;
    assign accept       = load_valid & ~pending_full;
    assign transfer     = tick & (idx == IDX_W'(NUM_DIGITS - 1)) & pending_full;
    assign idx_next     = idx + 1'b1;
    // Outputs are registered from the post-tick view so they change on the tick edge itself.
    assign display_next = transfer ? pending : display;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            display      <= '0;
            nibble       <= '0;
            digit_en     <= 4'b0001;
            digit_blank  <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            if (accept) begin
                pending      <= load_data;
                pending_full <= 1'b1;
            end else if (transfer) begin
                pending_full <= 1'b0;
            end

            if (transfer) display <= pending;

            frame_start <= 1'b0;
            if (tick) begin
                idx         <= idx_next;
                nibble      <= digit_of(display_next, idx_next);
                digit_en    <= one_hot(idx_next);
                digit_blank <= blank_lz && (idx_next != '0) && upper_zero(display_next, idx_next);
                frame_start <= (idx_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Self-checking bench for hex_digit_scanner with CLK_DIV=4, using a time-based reference model.
module tb_hex_digit_scanner;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = 4 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = 16'h0000;
    logic        blank_lz = 1'b0;
    logic        load_ready;
    logic [3:0]  nibble;
    logic [3:0]  digit_en;
    logic        digit_blank;
    logic        frame_start;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    hex_digit_scanner #(.CLK_DIV(CLK_DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .blank_lz    (blank_lz),
        .nibble      (nibble),
        .digit_en    (digit_en),
        .digit_blank (digit_blank),
        .frame_start (frame_start)
    );

    // Reference model: the slot shown follows from the number of edges since reset release.
    int          m_cyc;
    logic        m_full;
    logic [15:0] m_pend;
    logic [15:0] m_disp;
    logic [3:0]  e_nib;
    logic [3:0]  e_en;
    logic        e_blank;
    logic        e_fs;

    always @(posedge clk or negedge rst_n) begin
        int slot;
        bit acc;
        if (!rst_n) begin
            m_cyc = 0; m_full = 1'b0; m_pend = '0; m_disp = '0;
            e_nib = '0; e_en = 4'b0001; e_blank = 1'b0; e_fs = 1'b0;
        end else begin
            acc   = load_valid && !m_full;
            m_cyc = m_cyc + 1;
            e_fs  = 1'b0;
            if (m_cyc % CLK_DIV == 0) begin
                slot = (m_cyc / CLK_DIV) % 4;
                if (slot == 0 && m_full) begin
                    m_disp = m_pend;
                    m_full = 1'b0;
                end
                e_nib   = 4'((m_disp >> (4 * slot)) & 16'h000F);
                e_en    = 4'(1 << slot);
                e_blank = blank_lz && (slot != 0) && ((m_disp >> (4 * slot)) == 16'h0000);
                e_fs    = (slot == 0);
            end
            if (acc) begin
                m_pend = load_data;
                m_full = 1'b1;
            end
        end
    end

    logic [10:0] obs;
    logic [10:0] want;
    localparam logic [10:0] RESET_VEC = {4'h0, 4'b0001, 1'b0, 1'b0, 1'b1};
    assign obs  = {nibble, digit_en, digit_blank, frame_start, load_ready};
    assign want = {e_nib, e_en, e_blank, e_fs, !m_full};

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < FRAME + 2; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_valid = 1'b0; blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL reset_values got %h want %h", obs, RESET_VEC);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== want) begin
                errors++; $display("FAIL reset_release_model edge %0d got %h want %h", k, obs, want);
            end
            if (k == 3 || k == 4) begin
                vectors++;
                if (digit_en !== ((k == 4) ? 4'b0010 : 4'b0001)) begin
                    errors++; $display("FAIL first_tick edge %0d got %b", k, digit_en);
                end
            end
        end
    endtask

    task automatic test_load();
        bit ok;
        logic [3:0] nib_ref [4] = '{4'hF, 4'h7, 4'hA, 4'h3};
        wait_frame(ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL load_frame_timeout got 0 want 1"); end
        repeat (CLK_DIV) @(negedge clk);
        vectors++;
        if (digit_en !== 4'b0010) begin
            errors++; $display("FAIL load_in_digit1 got %b want 0010", digit_en);
        end
        load_valid = 1'b1; load_data = 16'h3A7F;
        @(negedge clk);
        load_valid = 1'b0; load_data = 16'($urandom);
        vectors++;
        if (load_ready !== 1'b0) begin
            errors++; $display("FAIL load_ready_drop got %b want 0", load_ready);
        end
        for (int k = 0; k < FRAME + 2; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== want) begin
                errors++; $display("FAIL load_model got %h want %h", obs, want);
            end
            if (frame_start === 1'b1) break;
            vectors++;
            if (nibble !== 4'h0) begin
                errors++; $display("FAIL load_no_tearing got %h want 0", nibble);
            end
        end
        for (int s = 0; s < 4; s++) begin
            vectors++;
            if ({nibble, digit_en, load_ready} !== {nib_ref[s], 4'(1 << s), 1'b1}) begin
                errors++;
                $display("FAIL load_slot%0d got %h/%b/%b want %h/%b/1", s, nibble, digit_en,
                         load_ready, nib_ref[s], 4'(1 << s));
            end
            repeat (CLK_DIV) @(negedge clk);
        end
    endtask

    task automatic test_blank();
        bit ok;
        logic [3:0] n42 [4] = '{4'h2, 4'h4, 4'h0, 4'h0};
        logic       b42 [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic       b00 [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        blank_lz = 1'b1;
        wait_frame(ok);
        load_valid = 1'b1; load_data = 16'h0042;
        @(negedge clk);
        load_valid = 1'b0;
        wait_frame(ok);
        vectors++;
        if (!ok) begin errors++; $display("FAIL blank_frame_timeout got 0 want 1"); end
        for (int s = 0; s < 4; s++) begin
            vectors++;
            if ({nibble, digit_blank, digit_en} !== {n42[s], b42[s], 4'(1 << s)}) begin
                errors++;
                $display("FAIL blank_0042_slot%0d got %h/%b want %h/%b", s, nibble, digit_blank,
                         n42[s], b42[s]);
            end
            repeat (CLK_DIV) @(negedge clk);
        end
        load_valid = 1'b1; load_data = 16'h0000;
        @(negedge clk);
        load_valid = 1'b0;
        wait_frame(ok);
        for (int s = 0; s < 4; s++) begin
            vectors++;
            if ({nibble, digit_blank, digit_en} !== {4'h0, b00[s], 4'(1 << s)}) begin
                errors++;
                $display("FAIL blank_0000_slot%0d got %h/%b want 0/%b", s, nibble, digit_blank,
                         b00[s]);
            end
            repeat (CLK_DIV) @(negedge clk);
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int stall;
        wait_frame(ok);
        load_valid = 1'b1; load_data = 16'h1111;
        @(negedge clk);
        load_data = 16'h2222;
        vectors++;
        if (load_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_stall got %b want 0", load_ready);
        end
        stall = 0;
        while (load_ready !== 1'b1 && stall < FRAME + 4) begin
            @(negedge clk);
            stall++;
        end
        vectors++;
        if ({load_ready, frame_start, nibble} !== {1'b1, 1'b1, 4'h1}) begin
            errors++;
            $display("FAIL b2b_first_shown got %b/%b/%h want 1/1/1", load_ready, frame_start, nibble);
        end
        @(negedge clk);
        load_valid = 1'b0;
        vectors++;
        if (load_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_second_accept got %b want 0", load_ready);
        end
        wait_frame(ok);
        vectors++;
        if ({ok, nibble, digit_en} !== {1'b1, 4'h2, 4'b0001}) begin
            errors++; $display("FAIL b2b_second_shown got %b/%h/%b want 1/2/0001", ok, nibble, digit_en);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        wait_frame(ok);
        load_valid = 1'b1; load_data = 16'hBEEF;
        @(negedge clk);
        load_valid = 1'b0;
        repeat (2 * CLK_DIV - 1) @(negedge clk);
        vectors++;
        if ({digit_en, load_ready} !== {4'b0100, 1'b0}) begin
            errors++; $display("FAIL midreset_setup got %b/%b want 0100/0", digit_en, load_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL midreset_values got %h want %h", obs, RESET_VEC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3 * FRAME; k++) begin
            @(negedge clk);
            vectors++;
            if (obs !== want || nibble !== 4'h0) begin
                errors++; $display("FAIL midreset_discard got %h want %h", obs, want);
            end
        end
    endtask

    task automatic test_freerun();
        int count = 0;
        int last = -1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                count++;
                vectors++;
                if (digit_en !== 4'b0001) begin
                    errors++; $display("FAIL freerun_en got %b want 0001", digit_en);
                end
                if (last >= 0) begin
                    vectors++;
                    if (k - last !== FRAME) begin
                        errors++; $display("FAIL freerun_spacing got %0d want %0d", k - last, FRAME);
                    end
                end
                last = k;
            end
        end
        vectors++;
        if (count !== 4) begin
            errors++; $display("FAIL freerun_count got %0d want 4", count);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            load_valid = 1'($urandom_range(0, 1));
            load_data  = 16'($urandom);
            blank_lz   = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (obs !== want) begin
                errors++; $display("FAIL random_cycle%0d got %h want %h", k, obs, want);
            end
        end
        load_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_blank();
        test_back_to_back();
        test_reset_mid();
        test_freerun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
